// File: rtl/systolic_operand_feeder.sv
// Buffers 3x3 operand matrices A/B and streams them into the 3x3 systolic array, then flushes and pulses done.
// Start-to-done latency is (3 + 2*SKEW) + FLUSH_CYCLES cycles; writes and start are accepted only while idle.
module systolic_operand_feeder #(
  parameter int DATA_W       = 8,
  parameter int FLUSH_CYCLES = 4,
  parameter int SKEW         = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              valid_out,
  output logic [DATA_W-1:0] a1,
  output logic [DATA_W-1:0] a2,
  output logic [DATA_W-1:0] a3,
  output logic [DATA_W-1:0] b1,
  output logic [DATA_W-1:0] b2,
  output logic [DATA_W-1:0] b3
);

  localparam int         L         = 3 + 2 * SKEW;
  localparam logic [2:0] LAST_BEAT = 3'(L - 1);
  localparam logic [3:0] FLUSH_M1  = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_t;

  state_t            r_state, w_state_nx;
  logic [2:0]        r_beat, w_beat_nx;
  logic [3:0]        r_flush, w_flush_nx;
  logic [DATA_W-1:0] r_a [9];
  logic [DATA_W-1:0] r_b [9];
  logic [DATA_W-1:0] w_a_nx [9];
  logic [DATA_W-1:0] w_b_nx [9];
  logic [DATA_W-1:0] r_ao [3];
  logic [DATA_W-1:0] r_bo [3];
  logic [DATA_W-1:0] w_ao [3];
  logic [DATA_W-1:0] w_bo [3];
  logic              r_busy, r_done, r_vld;

  // Buffer contents after this edge; the operand mux reads these so a write coinciding with start is streamed.
  always_comb begin
    for (int n = 0; n < 9; n++) begin
      w_a_nx[n] = r_a[n];
      w_b_nx[n] = r_b[n];
    end
    if (r_state == S_IDLE && wr_en && wr_addr <= 4'd8) begin
      if (wr_sel) w_b_nx[wr_addr] = wr_data;
      else        w_a_nx[wr_addr] = wr_data;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_beat_nx  = r_beat;
    w_flush_nx = r_flush;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_STREAM;
          w_beat_nx  = 3'd0;
        end
      end
      S_STREAM: begin
        if (r_beat == LAST_BEAT) begin
          w_state_nx = S_FLUSH;
          w_flush_nx = FLUSH_M1;
        end else begin
          w_beat_nx = r_beat + 3'd1;
        end
      end
      S_FLUSH: begin
        if (r_flush == 4'd0) w_state_nx = S_DONE;
        else                 w_flush_nx = r_flush - 4'd1;
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Lane i lags by i*SKEW beats; out-of-window lanes carry zero.
  always_comb begin
    int k;
    k = 0;
    for (int i = 0; i < 3; i++) begin
      w_ao[i] = '0;
      w_bo[i] = '0;
      if (w_state_nx == S_STREAM) begin
        k = int'(w_beat_nx) - i * SKEW;
        if (k >= 0 && k <= 2) begin
          w_ao[i] = w_a_nx[4'(i * 3 + k)];
          w_bo[i] = w_b_nx[4'(k * 3 + i)];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_flush <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_vld   <= 1'b0;
      for (int n = 0; n < 9; n++) begin
        r_a[n] <= '0;
        r_b[n] <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        r_ao[i] <= '0;
        r_bo[i] <= '0;
      end
    end else begin
      r_state <= w_state_nx;
      r_beat  <= w_beat_nx;
      r_flush <= w_flush_nx;
      r_busy  <= (w_state_nx == S_STREAM) || (w_state_nx == S_FLUSH);
      r_done  <= (w_state_nx == S_DONE);
      r_vld   <= (w_state_nx == S_STREAM);
      for (int n = 0; n < 9; n++) begin
        r_a[n] <= w_a_nx[n];
        r_b[n] <= w_b_nx[n];
      end
      for (int i = 0; i < 3; i++) begin
        r_ao[i] <= w_ao[i];
        r_bo[i] <= w_bo[i];
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign valid_out = r_vld;
  assign a1        = r_ao[0];
  assign a2        = r_ao[1];
  assign a3        = r_ao[2];
  assign b1        = r_bo[0];
  assign b2        = r_bo[1];
  assign b3        = r_bo[2];

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed bench for systolic_operand_feeder: one unskewed and one skewed instance checked against a matrix model and beat scoreboard.
module tb_systolic_operand_feeder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en0 = 1'b0, wr_en1 = 1'b0;
  logic       wr_sel = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start0 = 1'b0, start1 = 1'b0;

  logic       busy0, done0, vld0, busy1, done1, vld1;
  logic [7:0] a1_0, a2_0, a3_0, b1_0, b2_0, b3_0;
  logic [7:0] a1_1, a2_1, a3_1, b1_1, b2_1, b3_1;
  logic [47:0] ops0, ops1;
  assign ops0 = {a1_0, a2_0, a3_0, b1_0, b2_0, b3_0};
  assign ops1 = {a1_1, a2_1, a3_1, b1_1, b2_1, b3_1};

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  ma [9];
  logic [7:0]  mb [9];
  logic [47:0] q0 [$];
  logic [47:0] q1 [$];

  always #5 clk = ~clk;

  systolic_operand_feeder #(.DATA_W(8), .FLUSH_CYCLES(4), .SKEW(0)) u_dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en0), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start0), .busy(busy0), .done(done0), .valid_out(vld0),
    .a1(a1_0), .a2(a2_0), .a3(a3_0), .b1(b1_0), .b2(b2_0), .b3(b3_0));

  systolic_operand_feeder #(.DATA_W(8), .FLUSH_CYCLES(4), .SKEW(1)) u_dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en1), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start1), .busy(busy1), .done(done1), .valid_out(vld1),
    .a1(a1_1), .a2(a2_1), .a3(a3_1), .b1(b1_1), .b2(b2_1), .b3(b3_1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat t from the matrix model: lane i carries A[i][t-i*sk] and B[t-i*sk][i] when in 0..2.
  function automatic logic [47:0] exp_beat(input bit sk, input int t);
    logic [7:0] ea [3];
    logic [7:0] eb [3];
    int k;
    for (int i = 0; i < 3; i++) begin
      k = sk ? t - i : t;
      ea[i] = (k >= 0 && k <= 2) ? ma[i * 3 + k] : 8'h00;
      eb[i] = (k >= 0 && k <= 2) ? mb[k * 3 + i] : 8'h00;
    end
    return {ea[0], ea[1], ea[2], eb[0], eb[1], eb[2]};
  endfunction

  task automatic push_run(input bit sk);
    for (int t = 0; t < (sk ? 5 : 3); t++) begin
      if (sk) q1.push_back(exp_beat(1'b1, t));
      else    q0.push_back(exp_beat(1'b0, t));
    end
  endtask

  always @(negedge clk) begin
    if (vld0) begin
      if (q0.size() == 0) check("unexpected_beat0", 64'(ops0), 64'hDEAD);
      else                check("beat0", 64'(ops0), 64'(q0.pop_front()));
    end else if (busy0) check("flush_zero0", 64'(ops0), 64'h0);
    if (vld1) begin
      if (q1.size() == 0) check("unexpected_beat1", 64'(ops1), 64'hDEAD);
      else                check("beat1", 64'(ops1), 64'(q1.pop_front()));
    end else if (busy1) check("flush_zero1", 64'(ops1), 64'h0);
  end

  task automatic wr(input logic sel, input logic [3:0] addr, input logic [7:0] data);
    wr_sel = sel; wr_addr = addr; wr_data = data;
    wr_en0 = 1'b1; wr_en1 = 1'b1;
    @(posedge clk); #1;
    wr_en0 = 1'b0; wr_en1 = 1'b0;
    if (addr <= 4'd8) begin
      if (sel) mb[addr] = data;
      else     ma[addr] = data;
    end
  endtask

  // mode 0: plain run; 1: write+start while streaming; 2: start on done cycle then next cycle.
  task automatic run(input bit sk, input int mode);
    int vcnt, dcnt, dn;
    logic v, d, b;
    vcnt = 0; dcnt = 0; dn = 0;
    push_run(sk);
    if (sk) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0; wr_en0 = 1'b0; wr_en1 = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      v = sk ? vld1 : vld0;
      d = sk ? done1 : done0;
      b = sk ? busy1 : busy0;
      if (v) vcnt++;
      if (n == 1) check("busy_after_start", 64'(b), 64'h1);
      if (d) begin
        dcnt++;
        check("busy_low_on_done", 64'(b), 64'h0);
        if (dcnt == 1) dn = n;
      end
      if (mode == 1 && n == 2) begin
        wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'hFF;
        if (sk) begin wr_en1 = 1'b1; start1 = 1'b1; end
        else    begin wr_en0 = 1'b1; start0 = 1'b1; end
      end
      if (mode == 1 && n == 3) begin
        wr_en0 = 1'b0; wr_en1 = 1'b0; start0 = 1'b0; start1 = 1'b0;
      end
      if (mode == 2 && dn != 0) begin
        if (n == dn) begin
          if (sk) start1 = 1'b1; else start0 = 1'b1;
        end
        if (n == dn + 1) begin
          check("idle_after_done", 64'(b), 64'h0);
          push_run(sk);
        end
        if (n == dn + 2) begin
          check("busy_b2b", 64'(b), 64'h1);
          start0 = 1'b0; start1 = 1'b0;
        end
      end
    end
    check("valid_cycles", 64'(vcnt), 64'((sk ? 5 : 3) * (mode == 2 ? 2 : 1)));
    check("done_pulses", 64'(dcnt), 64'(mode == 2 ? 2 : 1));
    check("done_latency", 64'(dn), 64'((sk ? 5 : 3) + 4 + 1));
    check("queue_drained", 64'(sk ? q1.size() : q0.size()), 64'h0);
  endtask

  initial begin
    for (int n = 0; n < 9; n++) begin ma[n] = 8'h00; mb[n] = 8'h00; end
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs0", 64'({busy0, done0, vld0, ops0}), 64'h0);
    check("reset_outs1", 64'({busy1, done1, vld1, ops1}), 64'h0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Test 1/2: reference matrices, both skews
    for (int n = 0; n < 9; n++) wr(1'b0, 4'(n), 8'(n + 1));
    wr(1'b1, 4'd0, 8'd2); wr(1'b1, 4'd1, 8'd1); wr(1'b1, 4'd2, 8'd3);
    wr(1'b1, 4'd3, 8'd4); wr(1'b1, 4'd4, 8'd5); wr(1'b1, 4'd5, 8'd7);
    wr(1'b1, 4'd6, 8'd6); wr(1'b1, 4'd7, 8'd9); wr(1'b1, 4'd8, 8'd8);
    check("model_beat0", 64'(exp_beat(1'b0, 0)), 64'h01_04_07_02_01_03);
    check("model_skew_beat2", 64'(exp_beat(1'b1, 2)), 64'h03_05_07_06_05_03);
    run(1'b0, 0);
    run(1'b1, 0);

    // Test 3: write/start during streaming are ignored; replay shows original data
    run(1'b0, 1);
    run(1'b0, 0);

    // Test 5: out-of-range writes ignored; write coinciding with start is streamed
    for (int n = 9; n <= 15; n++) begin
      wr(1'b0, 4'(n), 8'hAA);
      wr(1'b1, 4'(n), 8'hAA);
    end
    wr_sel = 1'b0; wr_addr = 4'd8; wr_data = 8'h11;
    wr_en0 = 1'b1; wr_en1 = 1'b1;
    ma[8] = 8'h11;
    run(1'b0, 0);
    run(1'b1, 0);

    // Test 6: back-to-back
    run(1'b0, 2);

    // Test 4: asynchronous reset during flush
    push_run(1'b0);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (5) @(negedge clk);
    check("in_flush_before_reset", 64'({busy0, vld0}), 64'h2);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outs0", 64'({busy0, done0, vld0, ops0}), 64'h0);
    check("async_reset_outs1", 64'({busy1, done1, vld1, ops1}), 64'h0);
    q0.delete(); q1.delete();
    for (int n = 0; n < 9; n++) begin ma[n] = 8'h00; mb[n] = 8'h00; end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("no_done_in_reset", 64'({done0, busy0}), 64'h0);
    end
    reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("no_done_after_reset", 64'({done0, busy0}), 64'h0);
    end
    run(1'b0, 0);
    run(1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
